// File: rtl/retire_queue.sv
// Retirement FIFO between writeback and the trace/difftest harness, with sticky ebreak halt.
// Optional perf counters (instret, cycle) are built when RETIRE_PERF_EN is defined.
module retire_queue #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [ILEN-1:0]          in_instr,
  input  logic                     in_ebreak,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [ILEN-1:0]          out_instr,
  output logic                     out_ebreak,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count,
  output logic [CNT_W-1:0]         instret,
  output logic [CNT_W-1:0]         cycle
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [ILEN-1:0] instr_mem [DEPTH];
  logic            eb_mem    [DEPTH];

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  // Extra pointer MSB separates full from empty when the index bits match.
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign in_ready  = !full && !halted;
  assign out_valid = !empty;
  assign push      = rstn && in_valid && in_ready;
  assign pop       = rstn && out_valid && out_ready;
  assign count     = wr_ptr - rd_ptr;

  assign out_pc     = pc_mem[rd_ptr[AW-1:0]];
  assign out_instr  = instr_mem[rd_ptr[AW-1:0]];
  assign out_ebreak = eb_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      halted <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (push && in_ebreak) halted <= 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr[AW-1:0]]    <= in_pc;
      instr_mem[wr_ptr[AW-1:0]] <= in_instr;
      eb_mem[wr_ptr[AW-1:0]]    <= in_ebreak;
    end
  end

`ifdef RETIRE_PERF_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      instret <= '0;
      cycle   <= '0;
    end else begin
      if (push)    instret <= instret + CNT_W'(1);
      if (!halted) cycle   <= cycle + CNT_W'(1);
    end
  end
`else
  assign instret = '0;
  assign cycle   = '0;
`endif

endmodule

// File: tb/tb_retire_queue.sv
// Self-checking bench for retire_queue: per-scenario tasks plus a negedge scoreboard
// that models occupancy, halt and perf counters independently of the DUT.
module tb_retire_queue;

  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        eb;
  } entry_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ebreak;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        out_ebreak;
  logic        halted;
  logic [2:0]  count;
  logic [63:0] instret;
  logic [63:0] cycle;

  int checks = 0;
  int errors = 0;

  entry_t      exp_q[$];
  entry_t      head;
  bit          model_ok = 1'b0;
  logic        m_halted;
  logic [63:0] m_instret;
  logic [63:0] m_cycle;
  logic [31:0] sz;
  logic        m_ready;

  retire_queue #(.XLEN(64), .ILEN(32), .DEPTH(DEPTH), .CNT_W(64)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .in_instr(in_instr), .in_ebreak(in_ebreak),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .out_ebreak(out_ebreak),
    .halted(halted), .count(count), .instret(instret), .cycle(cycle)
  );

  always #5 clk = ~clk;

  // Scoreboard: check state, then predict the handshakes taken at the next posedge.
  always @(negedge clk) begin
    sz      = exp_q.size();
    m_ready = (sz < DEPTH) && !m_halted;
    if (model_ok) begin
      checks++;
      if (count !== sz[2:0]) begin
        errors++; $display("FAIL sb_count: got %0d expected %0d", count, sz);
      end
      checks++;
      if (out_valid !== (sz != 0)) begin
        errors++; $display("FAIL sb_out_valid: got %b expected %b", out_valid, sz != 0);
      end
      checks++;
      if (in_ready !== m_ready) begin
        errors++; $display("FAIL sb_in_ready: got %b expected %b", in_ready, m_ready);
      end
      checks++;
      if (halted !== m_halted) begin
        errors++; $display("FAIL sb_halted: got %b expected %b", halted, m_halted);
      end
      checks++;
      if (instret !== m_instret) begin
        errors++; $display("FAIL sb_instret: got %0d expected %0d", instret, m_instret);
      end
      checks++;
      if (cycle !== m_cycle) begin
        errors++; $display("FAIL sb_cycle: got %0d expected %0d", cycle, m_cycle);
      end
    end
    if (!rstn) begin
      exp_q.delete();
      m_halted  = 1'b0;
      m_instret = '0;
      m_cycle   = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (out_ready && sz != 0) begin
        head = exp_q.pop_front();
        checks++;
        if (out_pc !== head.pc || out_instr !== head.instr || out_ebreak !== head.eb) begin
          errors++;
          $display("FAIL sb_pop: got pc=%h instr=%h eb=%b expected pc=%h instr=%h eb=%b",
                   out_pc, out_instr, out_ebreak, head.pc, head.instr, head.eb);
        end
      end
`ifdef RETIRE_PERF_EN
      if (!m_halted) m_cycle = m_cycle + 64'd1;
      if (in_valid && m_ready) m_instret = m_instret + 64'd1;
`endif
      if (in_valid && m_ready) begin
        exp_q.push_back('{pc: in_pc, instr: in_instr, eb: in_ebreak});
        if (in_ebreak) m_halted = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    in_ebreak = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    for (int i = 0; i < n; i++) tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset(2);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
    checks++;
    if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret: got %0d expected 0", instret); end
  endtask

  task automatic test_fill_drain();
    logic [63:0] pcs [4];
    pcs = '{64'h80000000, 64'h80000004, 64'h80000008, 64'h8000000C};
    out_ready = 1'b0;
    in_instr  = 32'h00000013;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = pcs[i];
      tick();
    end
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL fill_count: got %0d expected 4", count); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %b expected 0", in_ready); end
    in_pc = 64'h80000010;
    tick();
    checks++;
    if (count !== 3'd4) begin errors++; $display("FAIL fill_drop: got count %0d expected 4", count); end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_pc !== pcs[i]) begin
        errors++; $display("FAIL drain_pc%0d: got %h expected %h", i, out_pc, pcs[i]);
      end
      tick();
    end
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL drain_count: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    in_instr  = 32'h00000013;
    in_ebreak = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h80001000 + 64'(4 * i);
      tick();
      checks++;
      if (count !== 3'd1) begin errors++; $display("FAIL stream_count%0d: got %0d expected 1", i, count); end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count: got %0d expected 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_instr  = 32'h00000013;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_pc    = 64'h80000200 + 64'(4 * i);
      tick();
    end
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL rmid_pre_count: got %0d expected 3", count); end
    out_ready = 1'b1;
    in_pc     = 64'h80000300;
    do_reset(1);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL rmid_count: got %0d expected 0", count); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (halted !== 1'b0) begin errors++; $display("FAIL rmid_halted: got %b expected 0", halted); end
    in_valid = 1'b1;
    in_pc    = 64'h80000100;
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h80000100) begin
      errors++; $display("FAIL rmid_first: got valid=%b pc=%h expected valid=1 pc=80000100", out_valid, out_pc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_halt();
    logic [63:0] pcs [3];
    pcs = '{64'h80000008, 64'h8000000C, 64'h80000010};
    idle_inputs();
    do_reset(1);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_pc     = pcs[i];
      in_ebreak = (i == 2);
      in_instr  = (i == 2) ? 32'h00100073 : 32'h00000013;
      tick();
    end
    in_ebreak = 1'b0;
    in_instr  = 32'h00000013;
    in_pc     = 64'h80000014;
    checks++;
    if (halted !== 1'b1) begin errors++; $display("FAIL halt_set: got %b expected 1", halted); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL halt_in_ready: got %b expected 0", in_ready); end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL halt_count: got %0d expected 3", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (out_pc !== pcs[i] || out_ebreak !== (i == 2)) begin
        errors++; $display("FAIL halt_drain%0d: got pc=%h eb=%b expected pc=%h eb=%b",
                           i, out_pc, out_ebreak, pcs[i], i == 2);
      end
      tick();
    end
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL halt_no_more: got out_valid %b expected 0", out_valid); end
    idle_inputs();
  endtask

  task automatic test_perf();
    bit          pat [8];
    logic [63:0] exp_inst;
    logic [63:0] exp_cyc;
    int          k;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    idle_inputs();
    do_reset(2);
    out_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid  = pat[i];
      in_pc     = 64'h80002000 + 64'(4 * k);
      in_ebreak = (i == 7);
      in_instr  = (i == 7) ? 32'h00100073 : 32'h00000013;
      if (pat[i]) k++;
      tick();
    end
    idle_inputs();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
`ifdef RETIRE_PERF_EN
    exp_inst = 64'd5;
    exp_cyc  = 64'd8;
`else
    exp_inst = 64'd0;
    exp_cyc  = 64'd0;
`endif
    checks++;
    if (instret !== exp_inst) begin errors++; $display("FAIL perf_instret: got %0d expected %0d", instret, exp_inst); end
    checks++;
    if (cycle !== exp_cyc) begin errors++; $display("FAIL perf_cycle: got %0d expected %0d", cycle, exp_cyc); end
    out_ready = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    idle_inputs();
    test_reset();
    test_fill_drain();
    test_stream();
    test_reset_mid();
    test_halt();
    test_perf();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
